// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-timer game controller.
package reaction_pkg;

  localparam int unsigned DEF_WIDTH      = 11;
  localparam int unsigned DEF_MIN_DELAY  = 500;
  localparam int unsigned DEF_TIMEOUT_MS = 2000;
  localparam int unsigned STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_ARM_WAIT    = 3'd1,
    ST_WAIT        = 3'd2,
    ST_ARM_REACT   = 3'd3,
    ST_REACT       = 3'd4,
    ST_RESULT      = 3'd5,
    ST_FALSE_START = 3'd6,
    ST_TIMEOUT     = 3'd7
  } state_e;

  typedef struct packed {
    logic timer_reset;
    logic timer_up;
    logic timer_enable;
    logic stimulus_led;
    logic result_valid;
    logic false_start;
    logic timeout;
  } ctrl_t;

  // Per-state timer/indicator controls; the reset value equals decode_ctrl(ST_IDLE).
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_IDLE:        c.timer_reset  = 1'b1;
      ST_ARM_WAIT:    c.timer_reset  = 1'b1;
      ST_WAIT:        c.timer_enable = 1'b1;
      ST_ARM_REACT: begin
        c.timer_reset  = 1'b1;
        c.timer_up     = 1'b1;
        c.stimulus_led = 1'b1;
      end
      ST_REACT: begin
        c.timer_up     = 1'b1;
        c.timer_enable = 1'b1;
        c.stimulus_led = 1'b1;
      end
      ST_RESULT:      c.result_valid = 1'b1;
      ST_FALSE_START: c.false_start  = 1'b1;
      ST_TIMEOUT:     c.timeout      = 1'b1;
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: random wait, stimulus, reaction capture and best-time tracking.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MIN_DELAY  = DEF_MIN_DELAY,
  parameter int unsigned TIMEOUT_MS = DEF_TIMEOUT_MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_pressed,
  input  logic             stop_pressed,
  input  logic [WIDTH-1:0] random_value,
  input  logic [WIDTH-1:0] timer_value,
  output logic             timer_reset,
  output logic             timer_up,
  output logic             timer_enable,
  output logic [WIDTH-1:0] start_value,
  output logic             stimulus_led,
  output logic [WIDTH-1:0] result_value,
  output logic [WIDTH-1:0] best_value,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout,
  output logic [2:0]       state_dbg
);

  localparam logic [WIDTH-1:0] MIN_DELAY_W  = WIDTH'(MIN_DELAY);
  localparam logic [WIDTH-1:0] TIMEOUT_W    = WIDTH'(TIMEOUT_MS);
  localparam logic [WIDTH-1:0] BEST_NONE    = '1;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [WIDTH-1:0] wait_clamped;

  assign wait_clamped = (random_value < MIN_DELAY_W) ? MIN_DELAY_W : random_value;

  // Next-state and datapath updates; controls are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    result_d = result_q;
    best_d   = best_q;

    case (state_q)
      ST_IDLE, ST_RESULT, ST_FALSE_START, ST_TIMEOUT: begin
        if (start_pressed) begin
          start_d = wait_clamped;
          state_d = ST_ARM_WAIT;
        end
      end
      ST_ARM_WAIT:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (stop_pressed)
          state_d = ST_FALSE_START;
        else if (timer_value == '0)
          state_d = ST_ARM_REACT;
      end
      ST_ARM_REACT: state_d = ST_REACT;
      ST_REACT: begin
        if (stop_pressed) begin
          result_d = timer_value;
          if (timer_value < best_q)
            best_d = timer_value;
          state_d = ST_RESULT;
        end else if (timer_value >= TIMEOUT_W) begin
          result_d = TIMEOUT_W;
          state_d  = ST_TIMEOUT;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= decode_ctrl(ST_IDLE);
      start_q  <= '0;
      result_q <= '0;
      best_q   <= BEST_NONE;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      start_q  <= start_d;
      result_q <= result_d;
      best_q   <= best_d;
    end
  end

  assign timer_reset  = ctrl_q.timer_reset;
  assign timer_up     = ctrl_q.timer_up;
  assign timer_enable = ctrl_q.timer_enable;
  assign stimulus_led = ctrl_q.stimulus_led;
  assign result_valid = ctrl_q.result_valid;
  assign false_start  = ctrl_q.false_start;
  assign timeout      = ctrl_q.timeout;
  assign start_value  = start_q;
  assign result_value = result_q;
  assign best_value   = best_q;
  assign state_dbg    = state_q;

endmodule
